// File: rtl/cic_decim_comb_if.sv
// Stream interface of the CIC decimator/comb section: input-rate samples in, decimated samples out.
interface cic_decim_comb_if #(
   parameter int WIDTH     = 64,
   parameter int OUT_WIDTH = 24,
   parameter int RATE_W    = 8
);
   logic                        in_strobe;
   logic [RATE_W-1:0]           decimation;
   logic signed [WIDTH-1:0]     in_data;
   logic                        out_strobe;
   logic signed [OUT_WIDTH-1:0] out_data;

   modport master (output in_strobe, decimation, in_data, input out_strobe, out_data);
   modport slave  (input in_strobe, decimation, in_data, output out_strobe, out_data);
endinterface

// File: rtl/cic_decim_comb.sv
// CIC decimator + comb chain: keeps every R-th strobed sample, runs STAGES combs (M=1), reduces to OUT_WIDTH.
// Optional CIC_COMB_ROUND_EN: round half up with positive saturation instead of plain truncation.
module cic_decim_comb #(
   parameter int WIDTH     = 64,
   parameter int OUT_WIDTH = 24,
   parameter int STAGES    = 5,
   parameter int RATE_W    = 8
) (
   input  logic             clock,
   input  logic             reset,
   cic_decim_comb_if.slave  bus
);
   logic [RATE_W-1:0]             cnt_q, cnt_d, r_act_q, r_act_d, r_load;
   logic                          dec;
   logic [STAGES+1:0]             vld_pipe_q, vld_pipe_d;
   logic [STAGES:0][WIDTH-1:0]    dat_q, dat_d;
   logic [STAGES-1:0][WIDTH-1:0]  dly_q, dly_d;
   logic [OUT_WIDTH-1:0]          out_data_q, out_data_d, red;

   assign r_load = (bus.decimation == '0) ? RATE_W'(1) : bus.decimation;
   assign dec    = bus.in_strobe && (cnt_q == r_act_q - RATE_W'(1));

   // Output reduction from the last comb result
   generate
      if (OUT_WIDTH < WIDTH) begin : g_red
         logic unused_lo;
         assign unused_lo = ^dat_q[STAGES][WIDTH-OUT_WIDTH-1:0];
`ifdef CIC_COMB_ROUND_EN
         logic [OUT_WIDTH-1:0] tr;
         logic                 rb;
         assign tr  = dat_q[STAGES][WIDTH-1 -: OUT_WIDTH];
         assign rb  = dat_q[STAGES][WIDTH-OUT_WIDTH-1];
         // only +max can overflow when adding the round bit
         assign red = (rb && tr == {1'b0, {(OUT_WIDTH-1){1'b1}}}) ? tr
                    : tr + {{(OUT_WIDTH-1){1'b0}}, rb};
`else
         assign red = dat_q[STAGES][WIDTH-1 -: OUT_WIDTH];
`endif
      end else begin : g_full
         assign red = dat_q[STAGES][OUT_WIDTH-1:0];
      end
   endgenerate

   always_comb begin
      cnt_d      = cnt_q;
      r_act_d    = r_act_q;
      dat_d      = dat_q;
      dly_d      = dly_q;
      out_data_d = out_data_q;
      // ratio reloads only at frame wrap so frames are never cut short or stretched
      if (bus.in_strobe) begin
         if (dec) begin
            cnt_d   = '0;
            r_act_d = r_load;
         end else begin
            cnt_d   = cnt_q + RATE_W'(1);
         end
      end
      vld_pipe_d = {vld_pipe_q[STAGES:0], dec};
      if (dec) dat_d[0] = bus.in_data;
      for (int k = 1; k <= STAGES; k++) begin
         if (vld_pipe_q[k-1]) begin
            dat_d[k]   = dat_q[k-1] - dly_q[k-1];
            dly_d[k-1] = dat_q[k-1];
         end
      end
      if (vld_pipe_q[STAGES]) out_data_d = red;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q      <= '0;
         r_act_q    <= r_load;
         vld_pipe_q <= '0;
         dat_q      <= '0;
         dly_q      <= '0;
         out_data_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         r_act_q    <= r_act_d;
         vld_pipe_q <= vld_pipe_d;
         dat_q      <= dat_d;
         dly_q      <= dly_d;
         out_data_q <= out_data_d;
      end
   end

   assign bus.out_strobe = vld_pipe_q[STAGES+1];
   assign bus.out_data   = out_data_q;
endmodule

// File: tb/tb_cic_decim_comb.sv
// Scoreboard bench for cic_decim_comb: reference = S-th order difference of the decimated sequence.
module tb_cic_decim_comb;
   localparam int W = 16, OW = 12, S = 2, RW = 4;
   localparam longint MASK  = (longint'(1) << W) - 1;
   localparam longint OMASK = (longint'(1) << OW) - 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   cic_decim_comb_if #(.WIDTH(W), .OUT_WIDTH(OW), .RATE_W(RW)) bus ();
   cic_decim_comb #(.WIDTH(W), .OUT_WIDTH(OW), .STAGES(S), .RATE_W(RW)) dut (
      .clock(clock), .reset(reset), .bus(bus));

   typedef struct { int due; logic [OW-1:0] val; } exp_t;
   exp_t    q[$];
   longint  hist[$];
   int      binom[S+1];
   int      cyc = 0, nvec = 0, nerr = 0, left = 1;
   logic [OW-1:0] hold = '0;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [OW-1:0] reduce(input longint y);
      longint tr, rb;
      tr = (y >> (W - OW)) & OMASK;
      rb = (y >> (W - OW - 1)) & 1;
`ifdef CIC_COMB_ROUND_EN
      if (!(tr == (OMASK >> 1) && rb == 1)) tr = (tr + rb) & OMASK;
`else
      rb = 0;
`endif
      return OW'(tr + rb * 0);
   endfunction

   function automatic int eff(input int dv);
      return (dv % (1 << RW) == 0) ? 1 : dv % (1 << RW);
   endfunction

   // Drives one cycle and advances the reference model for that cycle
   task automatic drive(input logic r, input logic st, input int dv, input longint d);
      longint y;
      int idx;
      @(posedge clock); #1;
      reset = r; bus.in_strobe = st; bus.decimation = RW'(dv); bus.in_data = W'(d);
      if (r) begin
         left = eff(dv);
         hist.delete();
         while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
      end else if (st) begin
         left--;
         if (left == 0) begin
            hist.push_back(d & MASK);
            y = 0;
            for (int j = 0; j <= S; j++) begin
               idx = hist.size() - 1 - j;
               if (idx >= 0) y += ((j % 2) ? -1 : 1) * binom[j] * hist[idx];
            end
            q.push_back('{cyc + S + 2, reduce(y & MASK)});
            left = eff(dv);
         end
      end
   endtask

   // Monitor: every output cycle is matched against the scoreboard head
   initial forever begin
      exp_t e;
      @(negedge clock);
      if (cyc >= 1) begin
         while (q.size() > 0 && q[0].due < cyc) begin
            nvec++; nerr++;
            $display("FAIL missing_strobe: expected sample %h due cycle %0d never seen", q[0].val, q[0].due);
            void'(q.pop_front());
         end
         nvec++;
         if (bus.out_strobe === 1'b1) begin
            if (q.size() == 0 || q[0].due != cyc) begin
               nerr++;
               $display("FAIL unexpected_strobe: out_strobe=1 at cycle %0d, no sample due", cyc);
            end else begin
               e = q.pop_front();
               if (bus.out_data !== e.val) begin
                  nerr++;
                  $display("FAIL out_data: cycle %0d got %h expected %h", cyc, bus.out_data, e.val);
               end
               hold = e.val;
            end
         end else if (q.size() > 0 && q[0].due == cyc) begin
            nerr++;
            $display("FAIL late_strobe: out_strobe=%b at cycle %0d, sample %h due", bus.out_strobe, cyc, q[0].val);
            void'(q.pop_front());
         end else if (bus.out_data !== hold) begin
            nerr++;
            $display("FAIL hold: cycle %0d out_data %h expected %h", cyc, bus.out_data, hold);
         end
         if (reset === 1'b1) hold = '0;
      end
   end

   initial begin
      longint d;
      int dv;
      binom[0] = 1;
      for (int j = 1; j <= S; j++) binom[j] = binom[j-1] * (S - j + 1) / j;
      bus.in_strobe = 1'b0; bus.decimation = RW'(4); bus.in_data = '0;

      repeat (3) drive(1, 0, 4, 0);
      // ramp of +3 per clock across the signed wrap point
      d = 64'h7FA0;
      for (int i = 0; i < 40; i++) begin drive(0, 1, 4, d & MASK); d += 3; end
      // ratio change mid-frame
      for (int i = 0; i < 30; i++) begin drive(0, 1, (i < 2) ? 4 : 2, d & MASK); d += 3; end
      // sparse strobes with decimation = 0
      for (int i = 0; i < 30; i++) drive(0, (i % 3) == 0, 0, longint'($urandom) & MASK);
      // reset with samples in flight, strobe coincident with reset
      for (int i = 0; i < 3; i++) drive(0, 1, 1, longint'($urandom) & MASK);
      drive(1, 0, 1, 0);
      drive(1, 1, 3, longint'($urandom) & MASK);
      for (int i = 0; i < 15; i++) drive(0, 1, 3, longint'($urandom) & MASK);
      // first output after reset equals the captured sample: rounding boundaries
      drive(1, 0, 1, 0); drive(0, 1, 1, 64'h0018); drive(0, 0, 1, 0);
      drive(1, 0, 1, 0); drive(0, 1, 1, 64'h7FF8); drive(0, 0, 1, 0);
      drive(1, 0, 1, 0); drive(0, 1, 1, 64'hFFF8); drive(0, 0, 1, 0);
      drive(1, 0, 1, 0); drive(0, 1, 1, 64'h8000);
      for (int i = 0; i < S + 3; i++) drive(0, 0, 1, 0);
      // random traffic
      dv = 3;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(19) == 0) dv = $urandom_range(5);
         drive($urandom_range(99) == 0, $urandom_range(9) < 7, dv, longint'($urandom) & MASK);
      end
      repeat (S + 5) drive(0, 0, dv, 0);
      nvec++;
      if (q.size() != 0) begin
         nerr++;
         $display("FAIL drain: %0d samples still pending, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
